// File: rtl/gb_apu_pkg.sv
// Shared types for the APU wave RAM block: address/byte types, arbiter states
// and the address-redirection helper used by the wave RAM controller.
package gb_apu_pkg;

  localparam int unsigned WAVE_RAM_DEPTH = 16;

  typedef logic [3:0] wave_addr_t;
  typedef logic [7:0] wave_byte_t;

  typedef enum logic {
    WAVE_IDLE = 1'b0,
    WAVE_PEND = 1'b1
  } wave_arb_state_t;

  // While the channel plays, the CPU can only reach the byte being played.
  function automatic wave_addr_t wave_eff_addr(input logic       ch_on,
                                               input wave_addr_t ch_addr,
                                               input wave_addr_t cpu_addr);
    return ch_on ? ch_addr : cpu_addr;
  endfunction

endpackage

// File: rtl/gb_apu_wave_ram.sv
// 16x8 single-port wave RAM: synchronous write, registered synchronous read.
// Contents are deliberately not reset.
module gb_apu_wave_ram (
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  import gb_apu_pkg::*;

  wave_byte_t mem_r [WAVE_RAM_DEPTH];
  wave_byte_t rdata_r;

  // Single shared port: write and read use the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/gb_apu_wave_ram_ctrl.sv
// Wave RAM arbiter: channel 3 fetches win, CPU accesses are buffered one deep.
// Define GB_APU_WAVE_DMG_QUIRK_EN for DMG behaviour (CPU access only inside the fetch window).
module gb_apu_wave_ram_ctrl
`ifdef GB_APU_WAVE_DMG_QUIRK_EN
  #(parameter int unsigned WINDOW_CYCLES = 2)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ready,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       ch_on,
  input  logic       ch_fetch,
  input  logic [3:0] ch_addr,
  output logic [7:0] ch_data
);
  import gb_apu_pkg::*;

  wave_arb_state_t state_r;
  wave_addr_t      addr_r;
  logic            we_r;
  wave_byte_t      wdata_r;
  logic            cpu_ready_r;
  logic            cpu_ack_r;
  wave_byte_t      cpu_rdata_r;
  logic            cpu_rd_r;
  wave_byte_t      ch_data_r;
  logic            ch_rd_r;

  logic            exec_s;
  logic            allow_s;
  logic            ram_we_s;
  logic            ram_re_s;
  wave_addr_t      eff_addr_s;
  wave_addr_t      ram_addr_s;
  wave_byte_t      ram_rdata_s;

`ifdef GB_APU_WAVE_DMG_QUIRK_EN
  logic [3:0] window_r;

  // Access window: reloaded by every fetch, then counts down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_r <= 4'd0;
    end else if (ch_fetch) begin
      window_r <= 4'(WINDOW_CYCLES);
    end else if (window_r != 4'd0) begin
      window_r <= window_r - 4'd1;
    end else begin
      window_r <= window_r;
    end
  end

  assign allow_s = !(ch_on && (window_r == 4'd0));
`else
  assign allow_s = 1'b1;
`endif

  // Port arbitration: a fetch owns the port, otherwise a pending CPU access executes.
  always_comb begin
    exec_s     = 1'b0;
    eff_addr_s = 4'd0;
    ram_addr_s = 4'd0;
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    exec_s     = (state_r == WAVE_PEND) && !ch_fetch;
    eff_addr_s = wave_eff_addr(ch_on, ch_addr, addr_r);
    if (ch_fetch) begin
      ram_addr_s = ch_addr;
      ram_re_s   = 1'b1;
    end else begin
      ram_addr_s = eff_addr_s;
      ram_we_s   = exec_s && we_r && allow_s && !reset;
      ram_re_s   = exec_s && !we_r && allow_s;
    end
  end

  gb_apu_wave_ram u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (ram_addr_s),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  // CPU request buffer and retire handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= WAVE_IDLE;
      addr_r      <= 4'd0;
      we_r        <= 1'b0;
      wdata_r     <= 8'h00;
      cpu_ready_r <= 1'b1;
      cpu_ack_r   <= 1'b0;
      cpu_rdata_r <= 8'hFF;
      cpu_rd_r    <= 1'b0;
    end else begin
      cpu_ack_r <= 1'b0;
      cpu_rd_r  <= 1'b0;
      if (cpu_rd_r) begin
        cpu_rdata_r <= ram_rdata_s;
      end
      case (state_r)
        WAVE_IDLE: begin
          if (cpu_req && cpu_ready_r) begin
            addr_r      <= cpu_addr;
            we_r        <= cpu_we;
            wdata_r     <= cpu_wdata;
            cpu_ready_r <= 1'b0;
            state_r     <= WAVE_PEND;
          end
        end
        WAVE_PEND: begin
          if (exec_s) begin
            state_r     <= WAVE_IDLE;
            cpu_ready_r <= 1'b1;
            cpu_ack_r   <= 1'b1;
            // A blocked read still acks, but returns open-bus 0xFF.
            if (!we_r) begin
              if (allow_s) begin
                cpu_rd_r <= 1'b1;
              end else begin
                cpu_rdata_r <= 8'hFF;
              end
            end
          end
        end
        default: begin
          state_r     <= WAVE_IDLE;
          cpu_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Channel byte holding register; refreshed only by channel fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_data_r <= 8'h00;
      ch_rd_r   <= 1'b0;
    end else begin
      ch_rd_r <= ch_fetch;
      if (ch_rd_r) begin
        ch_data_r <= ram_rdata_s;
      end
    end
  end

  assign cpu_ready = cpu_ready_r;
  assign cpu_ack   = cpu_ack_r;
  assign cpu_rdata = cpu_rd_r ? ram_rdata_s : cpu_rdata_r;
  assign ch_data   = ch_rd_r ? ram_rdata_s : ch_data_r;

endmodule

// File: tb/tb_gb_apu_wave_ram_ctrl.sv
// Scoreboard bench for gb_apu_wave_ram_ctrl: stimulus queues expected acks,
// a negedge monitor pops and compares each cpu_ack.
module tb_gb_apu_wave_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic       cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ready;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       ch_on;
  logic       ch_fetch;
  logic [3:0] ch_addr;
  logic [7:0] ch_data;

`ifdef GB_APU_WAVE_DMG_QUIRK_EN
  localparam bit QUIRK = 1'b1;
`else
  localparam bit QUIRK = 1'b0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rd = 8'hFF;

  gb_apu_wave_ram_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ch_on     (ch_on),
    .ch_fetch  (ch_fetch),
    .ch_addr   (ch_addr),
    .ch_data   (ch_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: every ack retires the oldest queued access; rdata must match the last read.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_rd = 8'hFF;
    end else if (cpu_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack rdata actual=%h required=no ack", cpu_rdata);
      end else begin
        e = sb.pop_front();
        if (!e.we) last_rd = e.data;
        if (cpu_rdata !== last_rd) begin
          errors++;
          $display("FAIL %s_ack rdata actual=%h required=%h",
                   e.we ? "write" : "read", cpu_rdata, last_rd);
        end
      end
    end
  end

  function automatic logic [7:0] pat(input int i);
    return {4'(i), ~4'(i)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(cpu_ready), 32'd1);
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 20; n++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("ack_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic cpu_present(input logic we, input int addr, input logic [7:0] wd,
                             input logic [7:0] exp);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = 4'(addr);
    cpu_wdata = wd;
    sb.push_back(exp_t'{we, exp});
  endtask

  task automatic cpu_do(input logic we, input int addr, input logic [7:0] wd,
                        input logic [7:0] exp);
    wait_ready();
    cpu_present(we, addr, wd, exp);
    tick();
    cpu_req = 1'b0;
    wait_empty();
  endtask

  initial begin
    int cyc;
    int issued;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_wdata = 8'h00;
    ch_on = 1'b0; ch_fetch = 1'b0; ch_addr = 4'd0;
    tick(); tick(); tick();
    reset = 1'b0;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'hFF);
    check("rst_ch_data", 32'(ch_data), 32'h00);

    // 1: plain write/read with exact latency
    cpu_present(1'b1, 3, 8'hA5, 8'h00);
    tick();
    cpu_req = 1'b0;
    check("t1_busy_ready", 32'(cpu_ready), 32'd0);
    check("t1_early_ack", 32'(cpu_ack), 32'd0);
    tick();
    check("t1_ack", 32'(cpu_ack), 32'd1);
    check("t1_ready_back", 32'(cpu_ready), 32'd1);
    cpu_do(1'b0, 3, 8'h00, 8'hA5);

    // 2: pending write loses to a 3-cycle fetch of the same byte
    cpu_do(1'b1, 5, 8'h5A, 8'h00);
    ch_fetch = 1'b1; ch_addr = 4'd5;
    cpu_present(1'b1, 5, 8'h12, 8'h00);
    tick();
    cpu_req = 1'b0;
    check("t2_ack_f1", 32'(cpu_ack), 32'd0);
    tick();
    check("t2_ack_f2", 32'(cpu_ack), 32'd0);
    tick();
    ch_fetch = 1'b0;
    check("t2_ack_f3", 32'(cpu_ack), 32'd0);
    check("t2_ch_old", 32'(ch_data), 32'h5A);
    tick();
    check("t2_ack_late", 32'(cpu_ack), 32'd1);
    check("t2_ch_kept", 32'(ch_data), 32'h5A);
    wait_empty();
    cpu_do(1'b0, 5, 8'h00, 8'h12);

    // 3: redirected write while playing byte 7
    cpu_do(1'b1, 0, 8'h11, 8'h00);
    cpu_do(1'b1, 7, 8'h22, 8'h00);
    ch_on = 1'b1; ch_addr = 4'd7; ch_fetch = 1'b1;
    tick();
    ch_fetch = 1'b0;
    check("t3_ch_data", 32'(ch_data), 32'h22);
    cpu_do(1'b1, 0, 8'h3C, 8'h00);
    ch_on = 1'b0;
    cpu_do(1'b0, 7, 8'h00, 8'h3C);
    cpu_do(1'b0, 0, 8'h00, 8'h11);

    // 6: back-to-back with cpu_req held high
    cyc = 0;
    issued = 0;
    while (issued < 32 && cyc < 200) begin
      if (cpu_ready) begin
        if (issued < 16) cpu_present(1'b1, issued, pat(issued), 8'h00);
        else cpu_present(1'b0, issued - 16, 8'h00, pat(issued - 16));
        issued++;
      end
      tick();
      cyc++;
    end
    cpu_req = 1'b0;
    check("t6_cycles", 32'(cyc), 32'd63);
    wait_empty();

    // 5: reset while a write is stuck pending behind fetches
    ch_fetch = 1'b1; ch_addr = 4'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd2; cpu_wdata = 8'h77;
    tick();
    cpu_req = 1'b0;
    check("t5_pending", 32'(cpu_ready), 32'd0);
    tick();
    reset = 1'b1; ch_fetch = 1'b0;
    tick();
    reset = 1'b0;
    check("t5_ready", 32'(cpu_ready), 32'd1);
    check("t5_ack", 32'(cpu_ack), 32'd0);
    check("t5_rdata", 32'(cpu_rdata), 32'hFF);
    check("t5_ch_data", 32'(ch_data), 32'h00);
    tick();
    check("t5_no_late_ack", 32'(cpu_ack), 32'd0);
    cpu_do(1'b0, 2, 8'h00, 8'h2D);

    // 4: access window after a fetch of byte 9 (0x96)
    ch_on = 1'b1; ch_addr = 4'd9; ch_fetch = 1'b1;
    tick();
    ch_fetch = 1'b0;
    check("t4_ch_data", 32'(ch_data), 32'h96);
    cpu_do(1'b0, 4, 8'h00, 8'h96);
    for (int i = 0; i < 5; i++) tick();
    cpu_do(1'b0, 4, 8'h00, QUIRK ? 8'hFF : 8'h96);
    cpu_do(1'b1, 1, 8'h55, 8'h00);
    ch_on = 1'b0;
    cpu_do(1'b0, 9, 8'h00, QUIRK ? 8'h96 : 8'h55);
    cpu_do(1'b0, 1, 8'h00, 8'h1E);

    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
